dft16_frame_sched: RTL and testbench

- Sequencer wrapped around the combinational 16-point single-precision DFT core.
- Collects a frame of 16 real IEEE-754 samples from a serial valid/ready stream and presents them in parallel to the core.
- Holds the core inputs stable for a programmable settle time, captures the 16 complex results, then streams them out in natural order X0..X15.
- Sits between the sample source (ADC/FIFO side) and the spectrum consumer.

---
 rtl/dft16_frame_sched_if.sv | 26 ++
 rtl/dft16_frame_sched.sv | 201 ++++++++++++++++++++
 tb/tb_dft16_frame_sched.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dft16_frame_sched_if.sv
// Stream-side bundle of the DFT16 frame scheduler: sample input (s_*) and
// result output (m_*) handshakes. The scheduler connects through the master
// modport; the sample source / spectrum consumer side uses slave.
interface dft16_frame_sched_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;

    logic        m_valid;
    logic [31:0] m_re;
    logic [31:0] m_im;
    logic [3:0]  m_idx;
    logic        m_last;
    logic        m_ready;

    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_re, m_im, m_idx, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_re, m_im, m_idx, m_last
    );
endinterface

// File: rtl/dft16_frame_sched.sv
// DFT16 frame scheduler.
// Collects 16 real float samples from a valid/ready stream into a registered
// sample buffer that feeds the combinational DFT core, holds it for CORE_LAT
// cycles, captures the 16 complex bins into a result buffer and streams them
// out in order X0..X15. Float words are moved bit-exact; no arithmetic here.
//
// Build option: define DFT_SCHED_OVERLAP_EN to accept the next frame while the
// previous one drains (adds state FULL). Without it, input is accepted in LOAD
// only.
module dft16_frame_sched #(
    parameter int unsigned CORE_LAT = 4,   // settle cycles, 1..255
    parameter int unsigned CNT_W    = 8    // 2**CNT_W must exceed CORE_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dft16_frame_sched_if.master     bus,
    output logic [511:0]            core_x,
    output logic                    core_start,
    input  logic [1023:0]           core_X,
    output logic                    busy,
    output logic                    frame_err
);

`ifdef DFT_SCHED_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT);

    // FULL is only reachable when overlap is enabled.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        EVAL  = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         sidx_q, sidx_d;        // next sample slot
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // settle counter, 1..CORE_LAT in EVAL
    logic [3:0]         oidx_q, oidx_d;        // next bin to emit
    logic               frame_err_q, frame_err_d;
    logic [15:0][31:0]  sbuf_q;                // sample buffer, drives core_x
    logic [15:0][63:0]  rbuf_q;                // captured core results

    logic               s_ready_w;
    logic               m_valid_w;
    logic               core_start_w;
    logic               in_fire;
    logic               out_fire;
    logic               frame_done;
    logic               drain_done;
    logic               settle_done;

    // Handshake events shared by the next-state and datapath logic.
    assign in_fire     = bus.s_valid && s_ready_w;
    assign out_fire    = m_valid_w && bus.m_ready;
    assign frame_done  = in_fire && (sidx_q == 4'd15);
    assign drain_done  = out_fire && (oidx_q == 4'd15);
    assign settle_done = (state_q == EVAL) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame completion, settle expiry and end of drain.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (frame_done) state_d = EVAL;
            end
            EVAL: begin
                if (settle_done) state_d = DRAIN;
            end
            DRAIN: begin
                // A new frame completing together with the last bin goes
                // straight to EVAL; completing earlier parks in FULL.
                if (drain_done) begin
                    state_d = (OVERLAP && frame_done) ? EVAL : LOAD;
                end else if (OVERLAP && frame_done) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (drain_done) state_d = EVAL;
            end
            default: state_d = LOAD;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        s_ready_w    = 1'b0;
        m_valid_w    = 1'b0;
        core_start_w = 1'b0;
        unique case (state_q)
            LOAD:  s_ready_w = 1'b1;
            EVAL:  core_start_w = (cnt_q == CNT_ONE);
            DRAIN: begin
                m_valid_w = 1'b1;
                s_ready_w = OVERLAP;
            end
            FULL:  m_valid_w = 1'b1;
            default: ;
        endcase
    end

    // Next values for sample index, settle counter, output index and error.
    always_comb begin
        sidx_d      = sidx_q;
        cnt_d       = '0;
        oidx_d      = oidx_q;
        frame_err_d = 1'b0;

        if (in_fire) begin
            if (sidx_q == 4'd15) begin
                // Frame complete; a missing s_last is flagged but processed.
                sidx_d      = 4'd0;
                frame_err_d = !bus.s_last;
            end else if (bus.s_last) begin
                // Short frame: drop it and restart collection at slot 0.
                sidx_d      = 4'd0;
                frame_err_d = 1'b1;
            end else begin
                sidx_d = sidx_q + 4'd1;
            end
        end

        if (out_fire) begin
            oidx_d = oidx_q + 4'd1;   // wraps to 0 after bin 15
        end

        if (state_q == EVAL) begin
            cnt_d = settle_done ? '0 : cnt_q + CNT_ONE;
        end else if (state_d == EVAL) begin
            cnt_d = CNT_ONE;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sidx_q      <= 4'd0;
            cnt_q       <= '0;
            oidx_q      <= 4'd0;
            frame_err_q <= 1'b0;
        end else begin
            sidx_q      <= sidx_d;
            cnt_q       <= cnt_d;
            oidx_q      <= oidx_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Sample buffer: slot k written on input transfer k.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffers are reset so core_x and the result words read as
        // zero after reset rather than exposing stale data.
        if (!rst_n) begin
            sbuf_q <= '0;
        end else if (in_fire) begin
            sbuf_q[sidx_q] <= bus.s_data;
        end
    end

    // Result buffer: snapshot of the core outputs at the end of settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_q <= '0;
        end else if (settle_done) begin
            rbuf_q <= core_X;
        end
    end

    // Outputs; result words are driven only while a bin is presented.
    assign core_x      = sbuf_q;
    assign core_start  = core_start_w;
    assign frame_err   = frame_err_q;
    assign busy        = !((state_q == LOAD) && (sidx_q == 4'd0));

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_w;
    assign bus.m_idx   = oidx_q;
    assign bus.m_last  = m_valid_w && (oidx_q == 4'd15);
    assign bus.m_re    = m_valid_w ? rbuf_q[oidx_q][31:0]  : 32'h0;
    assign bus.m_im    = m_valid_w ? rbuf_q[oidx_q][63:32] : 32'h0;

endmodule

// File: tb/tb_dft16_frame_sched.sv
// Directed bench for dft16_frame_sched with a behavioural 16-point DFT core.
module tb_dft16_frame_sched;
    localparam int CORE_LAT = 4;
    localparam logic [31:0] F_ONE     = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] F_TWO     = 32'h4000_0000;  // 2.0
    localparam logic [31:0] F_SIXTEEN = 32'h4180_0000;  // 16.0

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [511:0]  core_x;
    logic          core_start;
    logic [1023:0] core_X;
    logic          busy;
    logic          frame_err;

    dft16_frame_sched_if bus();

    dft16_frame_sched #(.CORE_LAT(CORE_LAT), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_x     (core_x),
        .core_start (core_start),
        .core_X     (core_X),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural DFT core ----------------
    function automatic real f2r(input logic [31:0] w);
        real m;
        int  e;
        if (w[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(w[22:0]) / 8388608.0;
        e = int'(w[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return w[31] ? -m : m;
    endfunction

    // Rounding residue of the trig sums collapses to +0.0.
    function automatic logic [31:0] r2f(input real v);
        logic [63:0] b;
        int          e;
        if (v < 1.0e-6 && v > -1.0e-6) return 32'h0;
        b = $realtobits(v);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [1023:0] dft(input logic [511:0] x);
        logic [1023:0] r;
        real re, im, xn, ang;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < 16; n++) begin
                xn  = f2r(x[32*n +: 32]);
                ang = 2.0 * 3.14159265358979 * real'(k * n) / 16.0;
                re  = re + xn * $cos(ang);
                im  = im - xn * $sin(ang);
            end
            r[64*k +: 32]      = r2f(re);
            r[64*k + 32 +: 32] = r2f(im);
        end
        return r;
    endfunction

    assign core_X = dft(core_x);

    // ---------------- monitors (sampled on the falling edge) ----------------
    int          cs_cnt = 0;
    int          fe_cnt = 0;
    int          out_cnt = 0;
    int          mv_sr1 = 0;   // cycles with m_valid=1 and s_ready=1
    int          mv_sr0 = 0;   // cycles with m_valid=1 and s_ready=0
    logic [3:0]  q_idx[$];
    logic [31:0] q_re[$];
    logic [31:0] q_im[$];
    logic        q_last[$];

    always @(negedge clk) begin
        if (core_start) cs_cnt++;
        if (frame_err) fe_cnt++;
        if (bus.m_valid && bus.s_ready) mv_sr1++;
        if (bus.m_valid && !bus.s_ready) mv_sr0++;
        if (bus.m_valid && bus.m_ready) begin
            q_idx.push_back(bus.m_idx);
            q_re.push_back(bus.m_re);
            q_im.push_back(bus.m_im);
            q_last.push_back(bus.m_last);
            out_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (bus.s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
        end
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // last_at: index carrying s_last (15 normal, <15 early, -1 never).
    task automatic send_frame(input logic [31:0] x0, input logic [31:0] xr, input int last_at);
        int cnt;
        cnt = (last_at >= 0 && last_at < 15) ? last_at + 1 : 16;
        for (int n = 0; n < cnt; n++) begin
            send_sample((n == 0) ? x0 : xr, n == last_at);
        end
    endtask

    // Called the cycle after the 16th handshake.
    task automatic check_latency(input string name);
        int lat;
        n_checks++;
        if (core_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_core_start: got %b, required 1", name, core_start);
        end
        lat = 1;
        while (bus.m_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat != CORE_LAT + 1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, CORE_LAT + 1);
        end
    endtask

    task automatic run_drain(input string name, input int n, input bit bp);
        int          cyc;
        int          base;
        bit          stalled;
        logic [3:0]  pat;
        logic [3:0]  h_idx;
        logic [31:0] h_re;
        logic [31:0] h_im;
        pat     = 4'b1001;
        cyc     = 0;
        stalled = 1'b0;
        base    = out_cnt;
        while (out_cnt - base < n && cyc < 400) begin
            bus.m_ready = bp ? pat[cyc % 4] : 1'b1;
            if (stalled) begin
                n_checks++;
                if ({bus.m_idx, bus.m_re, bus.m_im} !== {h_idx, h_re, h_im}) begin
                    n_fail++;
                    $display("FAIL %s_hold: got idx=%0d re=%h im=%h, required idx=%0d re=%h im=%h",
                             name, bus.m_idx, bus.m_re, bus.m_im, h_idx, h_re, h_im);
                end
            end
            stalled = bus.m_valid && !bus.m_ready;
            h_idx   = bus.m_idx;
            h_re    = bus.m_re;
            h_im    = bus.m_im;
            step();
            cyc++;
        end
        bus.m_ready = 1'b0;
        n_checks++;
        if (out_cnt - base != n) begin
            n_fail++;
            $display("FAIL %s_drain_count: got %0d transfers, required %0d", name, out_cnt - base, n);
        end
    endtask

    task automatic check_bins(input string name, input int base, input int n,
                              input logic [31:0] re0, input logic [31:0] rer);
        logic [31:0] e_re;
        if (q_idx.size() < base + n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_bins: got %0d recorded bins, required %0d", name, q_idx.size(), base + n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            e_re = (i == 0) ? re0 : rer;
            n_checks++;
            if ({q_idx[base+i], q_re[base+i], q_im[base+i], q_last[base+i]} !==
                {4'(i), e_re, 32'h0, (i == 15)}) begin
                n_fail++;
                $display("FAIL %s_bin%0d: got idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=00000000 last=%b",
                         name, i, q_idx[base+i], q_re[base+i], q_im[base+i], q_last[base+i], i, e_re, i == 15);
            end
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({bus.m_valid, bus.m_idx, bus.s_ready, busy} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_idle: got m_valid=%b m_idx=%0d s_ready=%b busy=%b, required 0 0 1 0",
                     name, bus.m_valid, bus.m_idx, bus.s_ready, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 32'h0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({bus.s_ready, bus.m_valid, bus.m_last, core_start, busy, frame_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got s_ready,m_valid,m_last,core_start,busy,frame_err=%b, required 100000",
                     {bus.s_ready, bus.m_valid, bus.m_last, core_start, busy, frame_err});
        end
        n_checks++;
        if ({bus.m_idx, bus.m_re, bus.m_im} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_data: got idx=%0d re=%h im=%h, required 0", bus.m_idx, bus.m_re, bus.m_im);
        end
        n_checks++;
        if (core_x !== 512'h0) begin
            n_fail++;
            $display("FAIL reset_core_x: got nonzero core_x, required 0");
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check_idle("reset_release");
    endtask

    task automatic test_impulse();
        int base, cs0;
        base = q_idx.size();
        cs0  = cs_cnt;
        send_frame(F_ONE, 32'h0, 15);
        check_latency("impulse");
        run_drain("impulse", 16, 1'b0);
        check_idle("impulse_end");
        check_bins("impulse", base, 16, F_ONE, F_ONE);
        n_checks++;
        if (cs_cnt - cs0 != 1) begin
            n_fail++;
            $display("FAIL impulse_start_pulses: got %0d, required 1", cs_cnt - cs0);
        end
    endtask

    task automatic test_backpressure();
        int base, sr1, oc;
        base = q_idx.size();
        sr1  = mv_sr1;
        send_frame(F_ONE, 32'h0, 15);
        check_latency("bp");
        run_drain("bp", 16, 1'b1);
        oc = out_cnt;
        check_idle("bp_end");
        bus.m_ready = 1'b1;
        repeat (8) step();
        bus.m_ready = 1'b0;
        n_checks++;
        if (out_cnt != oc) begin
            n_fail++;
            $display("FAIL bp_extra_transfers: got %0d, required 0", out_cnt - oc);
        end
        check_bins("bp", base, 16, F_ONE, F_ONE);
`ifndef DFT_SCHED_OVERLAP_EN
        n_checks++;
        if (mv_sr1 != sr1) begin
            n_fail++;
            $display("FAIL bp_s_ready_in_drain: got %0d cycles with s_ready=1, required 0", mv_sr1 - sr1);
        end
`endif
    endtask

    task automatic test_early_last();
        int base, cs0, fe0;
        cs0 = cs_cnt;
        fe0 = fe_cnt;
        send_frame(F_ONE, F_ONE, 6);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_err_pulse: got %b, required 1", frame_err);
        end
        step();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err_clear: got %b, required 0", frame_err);
        end
        repeat (5) step();
        check_idle("early_dropped");
        n_checks++;
        if ({cs_cnt - cs0, fe_cnt - fe0} != {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL early_counts: got core_start=%0d frame_err=%0d, required 0 1",
                     cs_cnt - cs0, fe_cnt - fe0);
        end
        base = q_idx.size();
        send_frame(F_ONE, F_ONE, 15);
        check_latency("early_next");
        run_drain("early_next", 16, 1'b0);
        check_bins("early_next", base, 16, F_SIXTEEN, 32'h0);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++;
            $display("FAIL early_next_err: got %0d pulses, required 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_missing_last();
        int base, fe0;
        base = q_idx.size();
        fe0  = fe_cnt;
        send_frame(F_TWO, 32'h0, -1);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_err_pulse: got %b, required 1", frame_err);
        end
        check_latency("missing");
        run_drain("missing", 16, 1'b0);
        check_bins("missing", base, 16, F_TWO, F_TWO);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++;
            $display("FAIL missing_err_count: got %0d, required 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_reset_mid_drain();
        int base, oc, cs0;
        base = q_idx.size();
        send_frame(F_ONE, 32'h0, 15);
        check_latency("rstmid");
        run_drain("rstmid", 8, 1'b0);
        check_bins("rstmid", base, 8, F_ONE, F_ONE);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_valid, bus.m_last, core_start, frame_err, busy, bus.m_idx, bus.m_re, bus.m_im} !== 73'h0) begin
            n_fail++;
            $display("FAIL rstmid_async_outputs: got m_valid=%b idx=%0d re=%h im=%h busy=%b, required all 0",
                     bus.m_valid, bus.m_idx, bus.m_re, bus.m_im, busy);
        end
        n_checks++;
        if ({bus.s_ready, core_x} !== {1'b1, 512'h0}) begin
            n_fail++;
            $display("FAIL rstmid_async_s_ready_core_x: got s_ready=%b, required 1 with core_x=0", bus.s_ready);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check_idle("rstmid_release");
        oc  = out_cnt;
        cs0 = cs_cnt;
        bus.m_ready = 1'b1;
        repeat (20) step();
        bus.m_ready = 1'b0;
        n_checks++;
        if ({out_cnt - oc, cs_cnt - cs0} != {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rstmid_no_residue: got transfers=%0d core_start=%0d, required 0 0",
                     out_cnt - oc, cs_cnt - cs0);
        end
    endtask

`ifdef DFT_SCHED_OVERLAP_EN
    task automatic test_back_to_back();
        int base, sr0;
        base = q_idx.size();
        sr0  = mv_sr0;
        bus.m_ready = 1'b1;
        send_frame(F_ONE, 32'h0, 15);
        check_latency("b2b_a");
        send_frame(F_ONE, F_ONE, 15);
        n_checks++;
        if ({core_start, bus.m_valid, 32'(q_idx.size() - base)} !== {1'b1, 1'b0, 32'd16}) begin
            n_fail++;
            $display("FAIL b2b_handover: got core_start=%b m_valid=%b bins=%0d, required 1 0 16",
                     core_start, bus.m_valid, q_idx.size() - base);
        end
        check_latency("b2b_b");
        run_drain("b2b_b", 16, 1'b0);
        check_bins("b2b_a", base, 16, F_ONE, F_ONE);
        check_bins("b2b_b", base + 16, 16, F_SIXTEEN, 32'h0);
        n_checks++;
        if (mv_sr0 != sr0) begin
            n_fail++;
            $display("FAIL b2b_s_ready_in_drain: got %0d cycles with s_ready=0, required 0", mv_sr0 - sr0);
        end
    endtask

    task automatic test_full();
        int base;
        base = q_idx.size();
        bus.m_ready = 1'b0;
        send_frame(F_ONE, 32'h0, 15);
        check_latency("full_a");
        send_frame(F_TWO, 32'h0, 15);
        n_checks++;
        if ({bus.s_ready, bus.m_valid, core_start} !== 3'b010) begin
            n_fail++;
            $display("FAIL full_state: got s_ready,m_valid,core_start=%b, required 010",
                     {bus.s_ready, bus.m_valid, core_start});
        end
        run_drain("full_a", 16, 1'b0);
        check_latency("full_b");
        run_drain("full_b", 16, 1'b0);
        check_bins("full_a", base, 16, F_ONE, F_ONE);
        check_bins("full_b", base + 16, 16, F_TWO, F_TWO);
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid_drain();
`ifdef DFT_SCHED_OVERLAP_EN
        test_back_to_back();
        test_full();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
